// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : mips_pkg                                               |
// | Description : Shared types and constants for the store buffer.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mips_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = 2;

    // One buffered store: full byte address and the word written.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wd;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sb_fwd_match                                           |
// | Description : Youngest-first word-address match across all buffered  |
// |               entries; scans from tail-1 backward to the oldest.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sb_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][29:0] word_adr,
    input  logic [DEPTH-1:0]       valid,
    input  logic [PTR_W-1:0]       tail,
    input  logic [29:0]            ld_word,
    output logic                   hit,
    output logic [PTR_W-1:0]       idx
);

    logic [PTR_W-1:0] w_pos;

    // Priority scan: the first match walking backward from tail-1 is the youngest.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_pos = tail - PTR_W'(k);
            if (!hit && valid[w_pos] && (word_adr[w_pos] == ld_word)) begin
                hit = 1'b1;
                idx = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mips_store_buffer                                      |
// | Description : FIFO store buffer between the MEM stage and data       |
// |               memory, with load forwarding and drain statistics.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mips_store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        full,
    output logic        empty,
    input  logic        ld_req,
    input  logic [31:0] ld_adr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    input  logic        mem_ack,
    output logic        overflow,
    output logic [15:0] retired
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);

    sb_entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [PTR_W:0]       r_count;
    logic                 r_overflow;
    logic [15:0]          r_retired;

    logic                 w_push;
    logic                 w_pop;
    logic [DEPTH-1:0]     w_valid;
    logic [DEPTH-1:0][29:0] w_word_adr;
    logic                 w_hit;
    logic [PTR_W-1:0]     w_idx;

    // Status flags come from the registered count only.
    assign full     = (r_count == FULL_COUNT);
    assign empty    = (r_count == '0);
    assign mem_we   = ~empty;
    assign overflow = r_overflow;
    assign retired  = r_retired;

    // A store while full is dropped even if the head drains on the same edge.
    assign w_push = memwrite & ~full;
    assign w_pop  = mem_we & mem_ack;

    // Head entry is presented directly; unoccupied slots are masked to zero.
    assign mem_adr = empty ? '0 : r_mem[r_head].adr;
    assign mem_wd  = empty ? '0 : r_mem[r_head].wd;

    // Pointers, occupancy, sticky overflow and drain counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_retired  <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop) begin
                r_head    <= r_head + 1'b1;
                r_retired <= r_retired + 16'd1;
            end
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (memwrite && full) r_overflow <= 1'b1;
        end
    end

    // Entry storage needs no reset: occupancy masks every read path.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= {dataadr, writedata};
    end

    // Per-slot occupancy (distance from head below count) and word address.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] w_offset;
        assign w_offset      = PTR_W'(i) - r_head;
        assign w_valid[i]    = ({1'b0, w_offset} < r_count);
        assign w_word_adr[i] = r_mem[i].adr[31:2];
    end

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd_match (
        .word_adr (w_word_adr),
        .valid    (w_valid),
        .tail     (r_tail),
        .ld_word  (ld_adr[31:2]),
        .hit      (w_hit),
        .idx      (w_idx)
    );

    assign ld_hit  = ld_req & w_hit;
    assign ld_data = ld_hit ? r_mem[w_idx].wd : '0;

endmodule
`default_nettype wire

// File: tb/tb_mips_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mips_store_buffer                                   |
// | Description : Scoreboard bench for mips_store_buffer with a queue    |
// |               model of buffer contents and randomized traffic.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mips_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wd;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        full, empty, ld_hit, mem_we, overflow;
    logic        ld_req = 1'b0;
    logic [31:0] ld_adr = '0;
    logic [31:0] ld_data, mem_adr, mem_wd;
    logic        mem_ack = 1'b0;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    ent_t        model[$];   // contents currently held, oldest first
    ent_t        exp_q[$];   // accepted stores awaiting drain
    logic        m_ovf = 1'b0;
    logic [15:0] m_ret = '0;

    mips_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .full      (full),
        .empty     (empty),
        .ld_req    (ld_req),
        .ld_adr    (ld_adr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_ack   (mem_ack),
        .overflow  (overflow),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drain monitor: every accepted handshake must deliver the oldest issued store.
    always @(negedge clk) begin
        if (reset && mem_we && mem_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_unexpected actual=%0h expected=none", mem_adr);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("drain_adr", mem_adr, e.adr);
                chk("drain_wd", mem_wd, e.wd);
            end
        end
    end

    task automatic check_state();
        logic        f_hit;
        logic [31:0] f_data;
        f_hit  = 1'b0;
        f_data = '0;
        for (int i = model.size() - 1; i >= 0; i--) begin
            if (!f_hit && model[i].adr[31:2] == ld_adr[31:2]) begin
                f_hit  = 1'b1;
                f_data = model[i].wd;
            end
        end
        if (!ld_req) begin
            f_hit  = 1'b0;
            f_data = '0;
        end
        chk("empty", {31'b0, empty}, {31'b0, model.size() == 0});
        chk("full", {31'b0, full}, {31'b0, model.size() == DEPTH});
        chk("mem_we", {31'b0, mem_we}, {31'b0, model.size() != 0});
        chk("head_adr", mem_adr, model.size() != 0 ? model[0].adr : 32'h0);
        chk("head_wd", mem_wd, model.size() != 0 ? model[0].wd : 32'h0);
        chk("ld_hit", {31'b0, ld_hit}, {31'b0, f_hit});
        chk("ld_data", ld_data, f_data);
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("retired", {16'b0, retired}, {16'b0, m_ret});
    endtask

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cycle(input logic mw, input logic [31:0] a, input logic [31:0] d,
                         input logic ack, input logic lr, input logic [31:0] la);
        logic pop, acc;
        memwrite = mw; dataadr = a; writedata = d;
        mem_ack = ack; ld_req = lr; ld_adr = la;
        @(negedge clk);
        check_state();
        pop = (model.size() > 0) && ack;
        acc = mw && (model.size() < DEPTH);
        if (mw && !acc) m_ovf = 1'b1;
        if (acc) exp_q.push_back('{a, d});
        if (pop) begin
            void'(model.pop_front());
            m_ret = m_ret + 16'd1;
        end
        if (acc) model.push_back('{a, d});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ack);
        cycle(1'b0, 32'h0, 32'h0, ack, 1'b0, 32'h0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        ld_req = 1'b1; ld_adr = 32'd84; memwrite = 1'b0; mem_ack = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_ld_hit", {31'b0, ld_hit}, 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_mem_adr", mem_adr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_retired", {16'b0, retired}, 32'd0);
        model.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_ret = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        do_reset();

        // First store appears at the memory port one cycle later.
        cycle(1'b1, 32'd84, 32'd7, 1'b0, 1'b0, 32'h0);
        idle(1'b0);

        // Fill to capacity, then one rejected store.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'd80 + 32'(4 * i), 32'(i + 1), 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'd96, 32'd5, 1'b0, 1'b0, 32'h0);
        idle(1'b0);

        // Forwarding picks the youngest of two matching stores.
        do_reset();
        cycle(1'b1, 32'd84, 32'd7, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'd84, 32'd9, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd86);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd100);
        // Head is still visible on the edge it drains; a same-cycle push is not.
        cycle(1'b1, 32'd200, 32'd11, 1'b1, 1'b1, 32'd84);
        cycle(1'b1, 32'd204, 32'd12, 1'b0, 1'b1, 32'd204);

        // Full with simultaneous pop: push rejected; then push+pop at count 2.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'd80 + 32'(4 * i), 32'(i + 1), 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'd100, 32'd6, 1'b1, 1'b0, 32'h0);
        idle(1'b1);
        cycle(1'b1, 32'd104, 32'd8, 1'b1, 1'b0, 32'h0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Six stores streamed with continuous acknowledge, crossing pointer wrap.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b0, 32'h0);
        idle(1'b1);
        idle(1'b1);
        chk("stream_retired", {16'b0, retired}, 32'd6);

        // Reset in the middle of a drain discards the rest.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + 32'(4 * i), 32'(i + 20), 1'b0, 1'b0, 32'h0);
        idle(1'b1);
        do_reset();
        idle(1'b1);

        // Randomized traffic on a narrow address window to provoke hits.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom % 2),
                  32'h100 + 32'($urandom % 8) * 4 + 32'($urandom % 4),
                  $urandom,
                  1'($urandom % 3 != 0),
                  1'($urandom % 2),
                  32'h100 + 32'($urandom % 10) * 4 + 32'($urandom % 4));
        end
        for (int n = 0; n < DEPTH + 2; n++) idle(1'b1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_store_buffer.md
MIPS_STORE_BUFFER -- requirements
Module: mips_store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered stores (power of two, ≥2).
REQ-002 Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- memwrite  in  1  store request from the MEM stage.
- dataadr  in  32  store byte address.
- writedata  in  32  store data.
- full  out  1  buffer holds DEPTH entries; the pipeline stalls its store.
- empty  out  1  buffer holds 0 entries.
- ld_req  in  1  load lookup valid.
- ld_adr  in  32  load byte address.
- ld_hit  out  1  a buffered store matches ld_adr.
- ld_data  out  32  data of the youngest matching entry.
- mem_we  out  1  drain write valid to data memory.
- mem_adr  out  32  head entry address.
- mem_wd  out  32  head entry data.
- mem_ack  in  1  data memory accepts the head entry this cycle.
- overflow  out  1  sticky: a store arrived while full and could not be accepted.
- retired  out  16  count of entries drained.

Function
REQ-003 Storage is a FIFO of DEPTH entries {adr[31:0], wd[31:0]}, with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
REQ-004 Push: on a clock edge with memwrite=1 and full=0, write {dataadr, writedata} at tail; tail wraps modulo DEPTH.
REQ-005 Pop: on a clock edge with mem_we=1 and mem_ack=1, advance head modulo DEPTH.
REQ-006 Push and pop on the same edge: both occur, and count is unchanged.
REQ-007 Push while full: the store is rejected even if a pop occurs on the same edge; overflow sets to 1 and holds until reset.
REQ-008 mem_we = !empty; mem_adr and mem_wd show the head entry combinationally; when empty they read 0.
REQ-009 mem_adr and mem_wd stay stable while mem_we=1 and mem_ack=0.
REQ-010 full = (count == DEPTH); empty = (count == 0); both derive from registered count only (no input-to-output path).
REQ-011 Forwarding (combinational):
- ld_hit = ld_req AND at least one valid entry has adr[31:2] == ld_adr[31:2].
- ld_data is the wd of the youngest matching entry; otherwise 0.
- The head is included even when it is popped this cycle.
- A store being pushed this cycle is excluded.
REQ-012 retired increments by 1 on each pop and wraps from 0xFFFF to 0.
REQ-013 Latency: a store pushed into an empty buffer produces mem_we=1 in the next cycle.
REQ-014 Byte lanes: the block handles full words only; dataadr[1:0] is stored and passed to mem_adr unchanged.

Reset
REQ-015 With reset=0, the following clear asynchronously: head, tail, count, overflow, retired. Outputs become empty=1, full=0, mem_we=0, ld_hit=0, mem_adr=0, mem_wd=0, ld_data=0.
REQ-016 Entry storage need not be cleared; unoccupied entries never reach any output.
REQ-017 Reset asserted mid-drain discards all entries; no mem_we follows until a new push.
REQ-018 Reset deassertion is synchronised externally; the first push is accepted on the first rising edge after reset=1.

Structure
REQ-019 A shared package mips_pkg holds:
- typedef sb_entry_t {adr, wd};
- constants SB_DEPTH=4 and SB_PTR_W=2.
REQ-020 One sub-module, sb_fwd_match: DEPTH-way priority match, youngest-first from tail-1 backward, returning the hit and the index.
REQ-021 The top level holds the pointers, count, storage, and counters only.

Verification
REQ-022 Reset, then push {84, 7} with mem_ack=0 -> next cycle: mem_we=1, mem_adr=84, mem_wd=7, empty=0.
REQ-023 Push {80,1}, {84,2}, {88,3}, {92,4} with mem_ack=0 -> full=1. Fifth push {96,5} -> overflow=1, and the entry count remains 4.
REQ-024 Buffer holds {84,7} then {84,9}; ld_req=1, ld_adr=86 -> ld_hit=1, ld_data=9. ld_adr=100 -> ld_hit=0, ld_data=0.
REQ-025 Full buffer with memwrite=1 and mem_ack=1 on the same edge -> one pop, push rejected, overflow=1, count=3. With count=2, simultaneous push and pop -> count stays 2.
REQ-026 Push 6 stores with mem_ack=1 continuously -> drain order and data match push order across pointer wrap; retired=6; empty=1 after the final pop.
REQ-027 Assert reset mid-drain with 3 entries -> empty=1 and mem_we=0 immediately; retired=0; overflow=0.
